// File: rtl/dla_ddr_feeder.sv
// DDR lane feeder: buffers wide memory words and serializes them onto one DLA lane.
// Optional DLA_FEEDER_CHECKSUM_EN adds o_checksum, the XOR of the burst's lane words.
module dla_ddr_feeder #(
  parameter int WIDE_W     = 64,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_burst_len,
  input  logic [WIDE_W-1:0] i_mem_data,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  output logic [DATA_W-1:0] o_ddr,
  output logic              o_ddr_valid,
  input  logic              i_ddr_ready,
  output logic              o_busy,
  output logic              o_done
`ifdef DLA_FEEDER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_checksum
`endif
);

  localparam int R     = WIDE_W / DATA_W;
  localparam int SUB_W = (R > 1) ? $clog2(R) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wlen_q, wlen_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  ld_q, ld_d;
  logic [LEN_W-1:0]  sent_q, sent_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
`ifdef DLA_FEEDER_CHECKSUM_EN
  logic [DATA_W-1:0] cks_q, cks_d;
`endif

  logic [WIDE_W-1:0] fifo_mem [FIFO_DEPTH];

  logic              active;
  logic              fifo_full;
  logic              fifo_empty;
  logic              mem_fire;
  logic              ddr_fire;
  logic              load;
  logic              pop;
  logic [DATA_W-1:0] sub_word;
  logic [LEN_W:0]    wsum;

  assign active      = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign fifo_full   = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty  = (cnt_q == '0);
  assign o_mem_ready = (state_q == S_STREAM) && !fifo_full
                       && (acc_q < wlen_q);
  assign mem_fire    = o_mem_ready && i_mem_valid;
  assign ddr_fire    = vld_q && i_ddr_ready;
  assign load        = active && !fifo_empty && (ld_q < len_q)
                       && (!vld_q || i_ddr_ready);
  // The head entry retires on its top sub-word or on the burst's last word,
  // so unused upper sub-words of a partial final word are dropped.
  assign pop         = load && ((sub_q == SUB_W'(R - 1))
                       || ((ld_q + LEN_W'(1)) == len_q));
  assign sub_word    = fifo_mem[rd_q][sub_q*DATA_W +: DATA_W];

  assign o_ddr       = dout_q;
  assign o_ddr_valid = vld_q;
  assign o_done      = (state_q == S_DONE);
  assign o_busy      = ((state_q == S_IDLE) && i_start) || active;
`ifdef DLA_FEEDER_CHECKSUM_EN
  assign o_checksum  = cks_q;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wlen_d  = wlen_q;
    acc_d   = acc_q;
    ld_d    = ld_q;
    sent_d  = sent_q;
    sub_d   = sub_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
`ifdef DLA_FEEDER_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    wsum    = {1'b0, i_burst_len} + (LEN_W+1)'(R - 1);

    if (mem_fire) begin
      wr_d  = wr_q + PW'(1);
      acc_d = acc_q + LEN_W'(1);
    end
    if (pop) begin
      rd_d  = rd_q + PW'(1);
      sub_d = '0;
    end else if (load) begin
      sub_d = sub_q + SUB_W'(1);
    end
    case ({mem_fire, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (load) begin
      dout_d = sub_word;
      vld_d  = 1'b1;
      ld_d   = ld_q + LEN_W'(1);
    end else if (ddr_fire) begin
      vld_d  = 1'b0;
    end
    if (ddr_fire) begin
      sent_d = sent_q + LEN_W'(1);
`ifdef DLA_FEEDER_CHECKSUM_EN
      cks_d  = cks_q ^ dout_q;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          len_d  = i_burst_len;
          wlen_d = LEN_W'(wsum / (LEN_W+1)'(R));
          acc_d  = '0;
          ld_d   = '0;
          sent_d = '0;
          sub_d  = '0;
          wr_d   = '0;
          rd_d   = '0;
          cnt_d  = '0;
          vld_d  = 1'b0;
`ifdef DLA_FEEDER_CHECKSUM_EN
          cks_d  = '0;
`endif
          state_d = (i_burst_len == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (mem_fire && ((acc_q + LEN_W'(1)) == wlen_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ddr_fire && ((sent_q + LEN_W'(1)) == len_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wlen_q  <= '0;
      acc_q   <= '0;
      ld_q    <= '0;
      sent_q  <= '0;
      sub_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
`ifdef DLA_FEEDER_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wlen_q  <= wlen_d;
      acc_q   <= acc_d;
      ld_q    <= ld_d;
      sent_q  <= sent_d;
      sub_q   <= sub_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
`ifdef DLA_FEEDER_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_fire) begin
      fifo_mem[wr_q] <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_dla_ddr_feeder.sv
// Scoreboard bench for dla_ddr_feeder: random memory/lane handshakes
// checked against lane words derived directly from the supplied wide words.
module tb_dla_ddr_feeder;

  localparam int WW = 64;
  localparam int DW = 16;
  localparam int LW = 16;
  localparam int R  = WW / DW;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic [LW-1:0] i_burst_len = '0;
  logic [WW-1:0] i_mem_data = '0;
  logic          i_mem_valid = 1'b0;
  logic          o_mem_ready;
  logic [DW-1:0] o_ddr;
  logic          o_ddr_valid;
  logic          i_ddr_ready = 1'b0;
  logic          o_busy;
  logic          o_done;
`ifdef DLA_FEEDER_CHECKSUM_EN
  logic [DW-1:0] o_checksum;
`endif

  dla_ddr_feeder dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_burst_len (i_burst_len),
    .i_mem_data  (i_mem_data),
    .i_mem_valid (i_mem_valid),
    .o_mem_ready (o_mem_ready),
    .o_ddr       (o_ddr),
    .o_ddr_valid (o_ddr_valid),
    .i_ddr_ready (i_ddr_ready),
    .o_busy      (o_busy),
`ifdef DLA_FEEDER_CHECKSUM_EN
    .o_checksum  (o_checksum),
`endif
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [WW-1:0] mem_q[$];
  int            mem_hs = 0;
  int            done_cnt = 0;
  int            xfer_cnt = 0;
  bit            fire_pend = 0;
  int            rdy_mode = 0;
  bit            mem_greedy = 0;
  logic [DW-1:0] chk_exp = '0;
  bit            prev_stall = 0;
  bit            prev_done = 0;
  logic [DW-1:0] prev_ddr = '0;
  int            cur_w = 0;
  int            cur_d0 = 0;
  int            cur_len = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    fire_pend = i_mem_valid && o_mem_ready;
    if (prev_stall) begin
      check("stall_hold_valid", 64'(o_ddr_valid), 64'd1);
      check("stall_hold_data", 64'(o_ddr), 64'(prev_ddr));
    end
    if (o_ddr_valid && i_ddr_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lane_extra: got %0h want no word", o_ddr);
      end else begin
        check("lane_word", 64'(o_ddr), 64'(exp_q.pop_front()));
      end
    end
    prev_stall = o_ddr_valid && !i_ddr_ready;
    prev_ddr   = o_ddr;
    if (o_done) begin
      done_cnt++;
      check("busy_at_done", 64'(o_busy), 64'd0);
      check("done_one_cycle", 64'(prev_done), 64'd0);
`ifdef DLA_FEEDER_CHECKSUM_EN
      check("checksum_at_done", 64'(o_checksum), 64'(chk_exp));
`endif
    end
    prev_done = o_done;
  end

  // Memory-side and lane-side drivers.
  always @(posedge clk) begin
    #1;
    if (fire_pend && mem_q.size() > 0) begin
      mem_q.delete(0);
      mem_hs++;
    end
    fire_pend = 0;
    if (mem_q.size() > 0 && (mem_greedy || $urandom_range(0, 9) < 7)) begin
      i_mem_valid = 1'b1;
      i_mem_data  = mem_q[0];
    end else begin
      i_mem_valid = 1'b0;
      i_mem_data  = {$urandom, $urandom};
    end
    case (rdy_mode)
      0:       i_ddr_ready = 1'b1;
      1:       i_ddr_ready = ($urandom_range(0, 3) != 0);
      default: i_ddr_ready = 1'b0;
    endcase
  end

  // mode 0: random words, 1: counting pattern, 2: checksum pattern
  task automatic begin_burst(int len, int mode);
    logic [WW-1:0] w;
    logic [WW-1:0] cur;
    logic [DW-1:0] lw;
    @(posedge clk);
    #2;
    cur_len = len;
    cur_w   = (len + R - 1) / R;
    cur_d0  = done_cnt;
    mem_hs  = 0;
    chk_exp = '0;
    for (int i = 0; i < cur_w + 1; i++) begin
      if (mode == 1) begin
        w = {16'(4*i+4), 16'(4*i+3), 16'(4*i+2), 16'(4*i+1)};
      end else if (mode == 2) begin
        w = 64'h8888_4444_2222_1111;
      end else begin
        w = {$urandom, $urandom};
      end
      mem_q.push_back(w);
    end
    for (int k = 0; k < len; k++) begin
      cur = mem_q[k / R];
      lw  = DW'(cur >> (DW * (k % R)));
      exp_q.push_back(lw);
      chk_exp = chk_exp ^ lw;
    end
    i_start     = 1'b1;
    i_burst_len = LW'(len);
    #1;
    check("busy_on_start", 64'(o_busy), 64'd1);
    @(posedge clk);
    #2;
    i_start = 1'b0;
  endtask

  task automatic finish_burst();
    int c;
    c = 0;
    while (done_cnt == cur_d0 && c < cur_len * 40 + 200) begin
      @(posedge clk);
      c++;
    end
    if (done_cnt == cur_d0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no o_done want o_done len=%0d", cur_len);
    end
    repeat (3) @(posedge clk);
    #2;
    check("all_words_out", 64'(exp_q.size()), 64'd0);
    check("mem_handshakes", 64'(mem_hs), 64'(cur_w));
    check("done_pulses", 64'(done_cnt - cur_d0), 64'd1);
    check("idle_not_busy", 64'(o_busy), 64'd0);
    mem_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_xfers(int n, string name);
    int x0;
    int c;
    x0 = xfer_cnt;
    c  = 0;
    while (xfer_cnt - x0 < n && c < 500) begin
      @(posedge clk);
      c++;
    end
    if (xfer_cnt - x0 < n) begin
      total++;
      bad++;
      $display("FAIL %s: got %0d transfers want %0d", name, xfer_cnt - x0, n);
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int lens[6];
    int d0;
    lens = '{1, 3, 4, 5, 2, 7};

    repeat (3) @(negedge clk);
    check("rst_mem_ready", 64'(o_mem_ready), 64'd0);
    check("rst_ddr", 64'(o_ddr), 64'd0);
    check("rst_ddr_valid", 64'(o_ddr_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    @(posedge clk);
    #2;
    i_reset = 1'b0;

    rdy_mode = 0;
    begin_burst(8, 1);
    finish_burst();
    begin_burst(6, 1);
    finish_burst();
    begin_burst(0, 1);
    finish_burst();

    begin_burst(64, 1);
    wait_xfers(8, "stall_lead_in");
    @(posedge clk);
    #2;
    rdy_mode   = 2;
    mem_greedy = 1;
    repeat (20) @(posedge clk);
    #2;
    check("mem_ready_backpressure", 64'(o_mem_ready), 64'd0);
    check("valid_while_stalled", 64'(o_ddr_valid), 64'd1);
    rdy_mode   = 0;
    mem_greedy = 0;
    finish_burst();

    begin_burst(16, 0);
    wait_xfers(5, "abort_lead_in");
    d0 = done_cnt;
    @(negedge clk);
    #2;
    i_reset    = 1'b1;
    fire_pend  = 0;
    prev_stall = 0;
    mem_q.delete();
    exp_q.delete();
    #1;
    check("abort_ddr_valid", 64'(o_ddr_valid), 64'd0);
    check("abort_ddr", 64'(o_ddr), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_mem_ready", 64'(o_mem_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    i_reset = 1'b0;
    repeat (2) @(posedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);

    begin_burst(4, 1);
    wait_xfers(1, "restart_lead_in");
    @(posedge clk);
    #2;
    i_start     = 1'b1;
    i_burst_len = LW'(9);
    @(posedge clk);
    #2;
    i_start = 1'b0;
    finish_burst();

`ifdef DLA_FEEDER_CHECKSUM_EN
    begin_burst(4, 2);
    finish_burst();
    check("checksum_ffff", 64'(o_checksum), 64'hFFFF);
`endif

    rdy_mode = 1;
    for (int n = 0; n < 14; n++) begin
      mem_greedy = ($urandom_range(0, 1) == 1);
      if (n < 6) begin
        begin_burst(lens[n], 0);
      end else begin
        begin_burst(int'($urandom_range(1, 40)), 0);
      end
      finish_burst();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
